// File: rtl/mmio_pkg.sv
// Shared types for the MMIO initiator: FSM state, queued command record, bus widths.
package mmio_pkg;

  localparam int unsigned MaskWidth = 4;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } mmio_state_e;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic                 we;
    logic [MaskWidth-1:0] mask;
    logic [DataWidth-1:0] wdata;
  } mmio_cmd_t;

  // A command with no byte lanes enabled never touches the bus.
  function automatic logic mask_active(input logic [MaskWidth-1:0] mask);
    return |mask;
  endfunction

endpackage

// File: rtl/mmio_cmd_fifo.sv
// Command queue for the MMIO initiator: DEPTH entries (power of two, >= 2) of mmio_cmd_t.
// A push while full is accepted only when a pop happens in the same cycle.
module mmio_cmd_fifo
  import mmio_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      push_i,
  input  mmio_cmd_t push_data_i,
  input  logic      pop_i,
  output mmio_cmd_t head_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("mmio_cmd_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  mmio_cmd_t       mem_q [DEPTH];
  logic            do_push, do_pop;

  assign full_o  = (count_q == (PtrW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; pointers wrap naturally at a power-of-two depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/mmio_initiator.sv
// MMIO initiator: queues commands and plays them one at a time onto a memory-map port
// (IDLE -> ISSUE -> WAIT -> RESP). Optional build macro MMIO_INITIATOR_TIMEOUT_EN adds a
// WAIT-state timeout that returns rsp_err=1 after TIMEOUT_CYCLES cycles without mem_resp.
module mmio_initiator
  import mmio_pkg::*;
#(
  parameter int unsigned CMD_DEPTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [AddrWidth-1:0] cmd_addr,
  input  logic                 cmd_we,
  input  logic [MaskWidth-1:0] cmd_mask,
  input  logic [DataWidth-1:0] cmd_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DataWidth-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic [AddrWidth-1:0] mem_addr,
  output logic [MaskWidth-1:0] mem_rmask,
  output logic [MaskWidth-1:0] mem_wmask,
  output logic [DataWidth-1:0] mem_wdata,
  input  logic [DataWidth-1:0] mem_rdata,
  input  logic                 mem_resp
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("mmio_initiator: TIMEOUT_CYCLES must be at least 2");
  end

  mmio_cmd_t   cmd_in, head;
  logic        fifo_full, fifo_empty, fifo_pop;

  mmio_state_e          state_q, state_d;
  logic                 cur_we_q, cur_we_d;
  logic [MaskWidth-1:0] cur_mask_q, cur_mask_d;
  logic [AddrWidth-1:0] mem_addr_q, mem_addr_d;
  logic [DataWidth-1:0] mem_wdata_q, mem_wdata_d;
  logic [DataWidth-1:0] rsp_rdata_q, rsp_rdata_d;

`ifdef MMIO_INITIATOR_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic            rsp_err_q, rsp_err_d;
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign cmd_in    = '{addr: cmd_addr, we: cmd_we, mask: cmd_mask, wdata: cmd_wdata};
  assign cmd_ready = !fifo_full;

  mmio_cmd_fifo #(
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (cmd_valid && cmd_ready),
    .push_data_i (cmd_in),
    .pop_i       (fifo_pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Masks are live only during the single ISSUE cycle; addr/wdata are registered and hold.
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rsp_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_rmask = (state_q == StIssue && !cur_we_q) ? cur_mask_q : '0;
  assign mem_wmask = (state_q == StIssue &&  cur_we_q) ? cur_mask_q : '0;

  // Transaction sequencer: next state, captured command and response data.
  always_comb begin
    state_d     = state_q;
    cur_we_d    = cur_we_q;
    cur_mask_d  = cur_mask_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    fifo_pop    = 1'b0;
`ifdef MMIO_INITIATOR_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
    rsp_err_d   = rsp_err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          cur_we_d   = head.we;
          cur_mask_d = head.mask;
          state_d    = StIssue;
          // A zero-mask command leaves the bus registers untouched.
          if (mask_active(head.mask)) begin
            mem_addr_d  = head.addr;
            mem_wdata_d = head.wdata;
          end
        end
      end
      StIssue: begin
        if (mask_active(cur_mask_q)) begin
          state_d = StWait;
`ifdef MMIO_INITIATOR_TIMEOUT_EN
          wait_cnt_d = CntW'(1);
`endif
        end else begin
          // Zero-mask command: no strobes were driven, answer directly without waiting.
          rsp_rdata_d = '0;
`ifdef MMIO_INITIATOR_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
          state_d     = StResp;
        end
      end
      StWait: begin
        if (mem_resp) begin
          rsp_rdata_d = cur_we_q ? '0 : mem_rdata;
          state_d     = StResp;
`ifdef MMIO_INITIATOR_TIMEOUT_EN
          rsp_err_d   = 1'b0;
          wait_cnt_d  = '0;
        end else if (wait_cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          // Next edge is TIMEOUT_CYCLES cycles after ISSUE.
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          wait_cnt_d  = '0;
          state_d     = StResp;
        end else begin
          wait_cnt_d = wait_cnt_q + CntW'(1);
`endif
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Sequencer state and bus/response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cur_we_q    <= 1'b0;
      cur_mask_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cur_we_q    <= cur_we_d;
      cur_mask_q  <= cur_mask_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifdef MMIO_INITIATOR_TIMEOUT_EN
  // Timeout counter and error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rsp_err_q  <= rsp_err_d;
    end
  end
`endif

endmodule

// File: tb/tb_mmio_initiator.sv
// Scoreboard bench for mmio_initiator: directed commands push expected responses into a
// queue; a monitor pops and compares on every response handshake. Honors
// MMIO_INITIATOR_TIMEOUT_EN for the no-response scenario.
`timescale 1ns/1ps
module tb_mmio_initiator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic        cmd_we = 1'b0;
  logic [3:0]  cmd_mask = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [3:0]  mem_rmask, mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_resp = 1'b0;

  always #5 clk = ~clk;

  mmio_initiator #(
    .CMD_DEPTH      (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_we    (cmd_we),
    .cmd_mask  (cmd_mask),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_addr  (mem_addr),
    .mem_rmask (mem_rmask),
    .mem_wmask (mem_wmask),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_resp  (mem_resp)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t expq[$];

  // GPIO-style peripheral: 16 word registers, byte-masked writes, answers in the cycle
  // after ISSUE unless stalled (then answers once the stall is released).
  logic [31:0] regs [16];
  logic        stall = 1'b0;
  logic        pend = 1'b0;
  logic [31:0] pend_data = '0;
  logic [31:0] nv;

  initial for (int i = 0; i < 16; i++) regs[i] = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_resp <= 1'b0;
      pend     <= 1'b0;
    end else begin
      mem_resp <= 1'b0;
      if (mem_wmask != 4'h0 || mem_rmask != 4'h0) begin
        nv = regs[mem_addr[5:2]];
        for (int b = 0; b < 4; b++) if (mem_wmask[b]) nv[8*b +: 8] = mem_wdata[8*b +: 8];
        regs[mem_addr[5:2]] = nv;
        if (stall) begin
          pend      <= 1'b1;
          pend_data <= nv;
        end else begin
          mem_resp  <= 1'b1;
          mem_rdata <= nv;
        end
      end else if (pend && !stall) begin
        mem_resp  <= 1'b1;
        mem_rdata <= pend_data;
        pend      <= 1'b0;
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (expq.size() == 0) begin
        check("unexpected_rsp_valid", {31'b0, rsp_valid}, 32'h0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
      end
    end
  end

  task automatic push(input logic [31:0] a, input logic we, input logic [3:0] m,
                      input logic [31:0] wd, input bit exp_rsp, input logic [31:0] er,
                      input logic ee);
    int guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      check("push_cmd_ready_timeout", {31'b0, cmd_ready}, 32'h1);
    end else begin
      cmd_valid = 1'b1;
      cmd_addr  = a;
      cmd_we    = we;
      cmd_mask  = m;
      cmd_wdata = wd;
      @(posedge clk);
      if (exp_rsp) expq.push_back('{rdata: er, err: ee});
      #1 cmd_valid = 1'b0;
    end
  endtask

  // Watches n cycles after a push; cycle 1 is the first cycle after the accepting edge.
  task automatic observe(input int n, output int fv, output int fi, output int wc,
                         output int rc, output logic [3:0] wm, output logic [31:0] wa,
                         output logic [31:0] wd);
    fv = -1; fi = -1; wc = 0; rc = 0; wm = '0; wa = '0; wd = '0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (rsp_valid && fv < 0) fv = k;
      if ((mem_wmask != 4'h0 || mem_rmask != 4'h0) && fi < 0) fi = k;
      if (mem_wmask != 4'h0) begin
        wc++; wm = mem_wmask; wa = mem_addr; wd = mem_wdata;
      end
      if (mem_rmask != 4'h0) rc++;
    end
  endtask

  task automatic drain(input string name);
    int guard = 0;
    while (expq.size() != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check(name, expq.size(), 32'h0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int fv, fi, wc, rc;
    logic [3:0]  wm;
    logic [31:0] wa, wd, addr_before;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'h1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err",   {31'b0, rsp_err}, 32'h0);
    check("rst_masks",     {24'b0, mem_rmask, mem_wmask}, 32'h0);
    check("rst_mem_addr",  mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);

    // GPIO write then read back, with minimum latency
    push(32'h4, 1'b1, 4'h1, 32'h0000_00A5, 1'b1, 32'h0, 1'b0);
    observe(6, fv, fi, wc, rc, wm, wa, wd);
    check("wr_latency", fv, 4);
    check("wr_wmask_cycles", wc, 1);
    check("wr_rmask_cycles", rc, 0);
    check("wr_issue_cycle", fi, 2);
    check("wr_wmask", {28'b0, wm}, 32'h1);
    check("wr_addr", wa, 32'h4);
    check("wr_wdata", wd, 32'hA5);
    drain("wr_drain");

    push(32'h4, 1'b0, 4'hF, 32'hDEAD_BEEF, 1'b1, 32'h0000_00A5, 1'b0);
    observe(6, fv, fi, wc, rc, wm, wa, wd);
    check("rd_latency", fv, 4);
    check("rd_rmask_cycles", rc, 1);
    check("rd_wmask_cycles", wc, 0);
    drain("rd_drain");

    // Zero-mask command: no bus activity, response 3 cycles after push
    addr_before = mem_addr;
    push(32'h8, 1'b1, 4'h0, 32'h5555_5555, 1'b1, 32'h0, 1'b0);
    observe(6, fv, fi, wc, rc, wm, wa, wd);
    check("zm_latency", fv, 3);
    check("zm_bus_activity", wc + rc, 0);
    check("zm_addr_hold", mem_addr, addr_before);
    drain("zm_drain");

    // Backpressure: response held 10 cycles, next command must not issue
    @(posedge clk); #1 rsp_ready = 1'b0;
    push(32'h4, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0000_00A5, 1'b0);
    push(32'h8, 1'b1, 4'hF, 32'h1234_5678, 1'b1, 32'h0, 1'b0);
    begin
      int guard = 0;
      while (!rsp_valid && guard < 50) begin
        @(negedge clk);
        guard++;
      end
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_rsp_valid", {31'b0, rsp_valid}, 32'h1);
      check("bp_rsp_rdata", rsp_rdata, 32'h0000_00A5);
      check("bp_no_issue", {24'b0, mem_rmask, mem_wmask}, 32'h0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    drain("bp_drain");

    // Five back-to-back commands against a stalled peripheral
    stall = 1'b1;
    push(32'h10, 1'b1, 4'hF, 32'h1111_1111, 1'b1, 32'h0, 1'b0);
    push(32'h10, 1'b0, 4'hF, 32'h0, 1'b1, 32'h1111_1111, 1'b0);
    push(32'h10, 1'b1, 4'h2, 32'h0000_AB00, 1'b1, 32'h0, 1'b0);
    push(32'h10, 1'b0, 4'hF, 32'h0, 1'b1, 32'h1111_AB11, 1'b0);
    push(32'h4,  1'b0, 4'hF, 32'h0, 1'b1, 32'h0000_00A5, 1'b0);
    @(negedge clk);
    check("full_cmd_ready", {31'b0, cmd_ready}, 32'h0);
    repeat (3) @(negedge clk);
    check("full_cmd_ready_hold", {31'b0, cmd_ready}, 32'h0);
    stall = 1'b0;
    drain("full_drain");

    // Peripheral that never answers
    stall = 1'b1;
`ifdef MMIO_INITIATOR_TIMEOUT_EN
    @(posedge clk); #1 rsp_ready = 1'b0;
    push(32'h0, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0, 1'b1);
    observe(22, fv, fi, wc, rc, wm, wa, wd);
    check("to_issue_cycle", fi, 2);
    check("to_latency_from_issue", fv - fi, 16);
    check("to_rsp_err", {31'b0, rsp_err}, 32'h1);
    check("to_rsp_rdata", rsp_rdata, 32'h0);
    @(posedge clk); #1 rsp_ready = 1'b1;
    drain("to_drain");
    stall = 1'b0;
    repeat (3) @(negedge clk);
    stall = 1'b1;
`else
    push(32'h0, 1'b0, 4'hF, 32'h0, 1'b0, 32'h0, 1'b0);
    observe(40, fv, fi, wc, rc, wm, wa, wd);
    check("nt_issue_cycle", fi, 2);
    check("nt_no_rsp", fv, -1);
    check("nt_cmd_ready", {31'b0, cmd_ready}, 32'h1);
`endif

    // Reset while waiting with commands queued
    push(32'h4, 1'b0, 4'hF, 32'h0, 1'b0, 32'h0, 1'b0);
    push(32'h8, 1'b0, 4'hF, 32'h0, 1'b0, 32'h0, 1'b0);
    push(32'hC, 1'b0, 4'hF, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_cmd_ready", {31'b0, cmd_ready}, 32'h1);
    check("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("mid_rst_rsp_rdata", rsp_rdata, 32'h0);
    check("mid_rst_rsp_err",   {31'b0, rsp_err}, 32'h0);
    check("mid_rst_masks",     {24'b0, mem_rmask, mem_wmask}, 32'h0);
    check("mid_rst_mem_addr",  mem_addr, 32'h0);
    check("mid_rst_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk) rst = 1'b0;
    stall = 1'b0;
    observe(20, fv, fi, wc, rc, wm, wa, wd);
    check("post_rst_no_rsp", fv, -1);
    check("post_rst_no_bus", wc + rc, 0);

    check("scoreboard_empty", expq.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
